irq_controller: RTL

Wishbone-slave interrupt controller between the peripherals' raw interrupt lines (I/O controller, touch panel, VGA, MMU fault, ...) and the CPU's 3-bit `interrupt` input. It synchronises up to seven request lines, latches edge- or level-mode requests into a pending register, masks them with a software enable register, and presents a registered priority code to the CPU. It replaces the ad hoc combinational priority logic in the SoC top level and is mapped in the I/O window, with chip-select decoding done by the MMU.

---
 rtl/irq_controller.sv | 70 +++++++
 1 files changed

// File: rtl/irq_controller.sv
// irq_controller: Wishbone-slave interrupt controller with synchronised edge/level requests,
// a software enable mask and a registered lowest-index-wins priority code for the CPU.
module irq_controller #(
    parameter int NSRC = 7
) (
    input  logic            sysclock,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq_i,
    input  logic [2:0]      adr_i,
    input  logic [31:0]     dat_i,
    input  logic [3:0]      sel_i,
    input  logic            we_i,
    input  logic            cyc_i,
    input  logic            stb_i,
    output logic [31:0]     dat_o,
    output logic            ack_o,
    output logic [2:0]      cpu_interrupt
);
    logic [NSRC-1:0] r_meta, r_s1, r_s2, r_pending, r_enable, r_mode;
    logic [NSRC-1:0] w_wdat, w_clr, w_rise, w_act, w_pend_nxt;
    logic            w_acc, w_wr, w_unused;
    logic [2:0]      w_code;
    logic [31:0]     w_rdat;

    assign w_acc  = cyc_i & stb_i & ~ack_o;
    assign w_wr   = w_acc & we_i & sel_i[0];
    assign w_wdat = dat_i[NSRC-1:0];
    assign w_clr  = (w_wr && adr_i == 3'd2) ? w_wdat : '0;
    assign w_rise = r_s1 & ~r_s2;
    // Edge bits: set beats clear. Level bits simply track the synchronised line.
    assign w_pend_nxt = (r_mode & ((r_pending & ~w_clr) | w_rise)) | (~r_mode & r_s1);
    assign w_act  = r_pending & r_enable;
    assign w_unused = ^{sel_i[3:1], dat_i[31:NSRC]};

    always_comb begin
        w_code = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (w_act[i]) w_code = 3'(i + 1);
    end

    assign w_rdat = adr_i == 3'd0 ? 32'(r_pending) :
                    adr_i == 3'd1 ? 32'(r_enable) :
                    adr_i == 3'd2 ? 32'(w_act) :
                    adr_i == 3'd3 ? 32'(r_mode) :
                    adr_i == 3'd4 ? 32'(cpu_interrupt) : '0;

    always_ff @(posedge sysclock or negedge rst_n) begin
        if (!rst_n) begin
            r_meta        <= '0;
            r_s1          <= '0;
            r_s2          <= '0;
            r_pending     <= '0;
            r_enable      <= '0;
            r_mode        <= '0;
            dat_o         <= '0;
            ack_o         <= 1'b0;
            cpu_interrupt <= '0;
        end else begin
            r_meta        <= irq_i;
            r_s1          <= r_meta;
            r_s2          <= r_s1;
            r_pending     <= w_pend_nxt;
            ack_o         <= w_acc;
            cpu_interrupt <= w_code;
            if (w_wr && adr_i == 3'd1) r_enable <= w_wdat;
            if (w_wr && adr_i == 3'd3) r_mode <= w_wdat;
            if (w_acc && !we_i) dat_o <= w_rdat;
        end
    end
endmodule
